simd_vector_regfile: RTL and testbench



---
 rtl/simd_rf_pkg.sv | 12 +
 rtl/simd_vector_regfile_if.sv | 34 +++
 rtl/simd_lane_register.sv | 23 ++
 rtl/simd_vector_regfile.sv | 81 ++++++++
 tb/tb_simd_vector_regfile.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/simd_rf_pkg.sv
// rtl/simd_rf_pkg.sv - shared constants and types for the SIMD vector register file
package simd_rf_pkg;
   localparam int RF_DEPTH     = 16;
   localparam int RF_LANES     = 4;
   localparam int RF_LANE_BITS = 32;
   localparam int RF_ADDR_BITS = $clog2(RF_DEPTH);

   typedef logic [RF_ADDR_BITS-1:0] rf_addr_t;
   typedef logic [RF_LANE_BITS-1:0] rf_lane_t;
   typedef rf_lane_t [RF_LANES-1:0] rf_vec_t;
   typedef logic [RF_LANES-1:0]     rf_mask_t;
endpackage

// File: rtl/simd_vector_regfile_if.sv
// rtl/simd_vector_regfile_if.sv - read/write/issue bundle between issue stage and register file
interface simd_vector_regfile_if
   import simd_rf_pkg::*;
#(
   parameter int DEPTH     = RF_DEPTH,
   parameter int LANES     = RF_LANES,
   parameter int LANE_BITS = RF_LANE_BITS
);
   localparam int AW = $clog2(DEPTH);
   localparam int W  = LANES * LANE_BITS;

   logic [AW-1:0]    rdAddr1;
   logic [AW-1:0]    rdAddr2;
   logic [W-1:0]     rdData1;
   logic [W-1:0]     rdData2;
   logic             rdBusy1;
   logic             rdBusy2;
   logic             wrEn;
   logic [AW-1:0]    wrAddr;
   logic [LANES-1:0] wrLaneMask;
   logic [W-1:0]     wrData;
   logic             issueEn;
   logic [AW-1:0]    issueAddr;

   modport master (
      output rdAddr1, rdAddr2, wrEn, wrAddr, wrLaneMask, wrData, issueEn, issueAddr,
      input  rdData1, rdData2, rdBusy1, rdBusy2
   );

   modport slave (
      input  rdAddr1, rdAddr2, wrEn, wrAddr, wrLaneMask, wrData, issueEn, issueAddr,
      output rdData1, rdData2, rdBusy1, rdBusy2
   );
endinterface

// File: rtl/simd_lane_register.sv
// rtl/simd_lane_register.sv - one vector entry with per-lane write enables
module simd_lane_register
   import simd_rf_pkg::*;
#(
   parameter int LANES     = RF_LANES,
   parameter int LANE_BITS = RF_LANE_BITS
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [LANES-1:0]           lane_en,
   input  logic [LANES*LANE_BITS-1:0] d,
   output logic [LANES*LANE_BITS-1:0] q
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else begin
         for (int l = 0; l < LANES; l++) begin
            if (lane_en[l]) q[l*LANE_BITS +: LANE_BITS] <= d[l*LANE_BITS +: LANE_BITS];
         end
      end
   end
endmodule

// File: rtl/simd_vector_regfile.sv
// rtl/simd_vector_regfile.sv - multi-lane vector register file with bypass and busy scoreboard
module simd_vector_regfile
   import simd_rf_pkg::*;
#(
   parameter int DEPTH     = RF_DEPTH,
   parameter int LANES     = RF_LANES,
   parameter int LANE_BITS = RF_LANE_BITS,
   parameter bit ZERO_REG  = 1'b1,
   parameter bit BYPASS    = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   simd_vector_regfile_if.slave rf
);
   localparam int AW    = $clog2(DEPTH);
   localparam int W     = LANES * LANE_BITS;
   localparam int FIRST = ZERO_REG ? 1 : 0;

   wire  [DEPTH-1:0][W-1:0] store;
   logic [DEPTH-1:0]        busy;
   logic [DEPTH-1:0]        busy_nxt;
   logic [1:0][AW-1:0]      rd_addr;
   logic [1:0][W-1:0]       rd_data;
   logic [1:0]              rd_busy;
   logic                    issue_ok;
   logic                    wr_fwd;

   if (ZERO_REG) begin : g_zero
      assign store[0] = '0;
   end

   for (genvar i = FIRST; i < DEPTH; i++) begin : g_entry
      logic [LANES-1:0] lane_en;
      assign lane_en = (rf.wrEn && rf.wrAddr == AW'(i)) ? rf.wrLaneMask : '0;
      simd_lane_register #(.LANES(LANES), .LANE_BITS(LANE_BITS)) u_reg (
         .clk     (clk),
         .rst_n   (rst_n),
         .lane_en (lane_en),
         .d       (rf.wrData),
         .q       (store[i])
      );
   end

   // Issue is applied after retire so a new producer keeps the entry busy.
   assign issue_ok = rf.issueEn && !(ZERO_REG && rf.issueAddr == '0);

   always_comb begin
      busy_nxt = busy;
      if (rf.wrEn) busy_nxt[rf.wrAddr] = 1'b0;
      if (issue_ok) busy_nxt[rf.issueAddr] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy <= '0;
      else        busy <= busy_nxt;
   end

   // Forwarding is gated by reset so the outputs read zero while rst_n is low.
   assign wr_fwd  = BYPASS && rst_n && rf.wrEn && !(ZERO_REG && rf.wrAddr == '0);
   assign rd_addr = {rf.rdAddr2, rf.rdAddr1};

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = store[rd_addr[p]];
         rd_busy[p] = busy[rd_addr[p]];
         if (wr_fwd && rf.wrAddr == rd_addr[p]) begin
            for (int l = 0; l < LANES; l++) begin
               if (rf.wrLaneMask[l]) rd_data[p][l*LANE_BITS +: LANE_BITS] = rf.wrData[l*LANE_BITS +: LANE_BITS];
            end
            if (&rf.wrLaneMask) rd_busy[p] = 1'b0;
         end
      end
   end

   assign rf.rdData1 = rd_data[0];
   assign rf.rdData2 = rd_data[1];
   assign rf.rdBusy1 = rd_busy[0];
   assign rf.rdBusy2 = rd_busy[1];
endmodule

// File: tb/tb_simd_vector_regfile.sv
// tb/tb_simd_vector_regfile.sv - self-checking bench, zero-reg+bypass and plain builds side by side
module tb_simd_vector_regfile;
   import simd_rf_pkg::*;

   localparam int W = RF_LANES * RF_LANE_BITS;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rf_addr_t     rd_a1, rd_a2, wr_addr, iss_addr;
   logic         wr_en, iss_en;
   rf_mask_t     wr_mask;
   logic [W-1:0] wr_data;

   simd_vector_regfile_if ifa ();
   simd_vector_regfile_if ifb ();

   assign ifa.rdAddr1 = rd_a1;    assign ifb.rdAddr1 = rd_a1;
   assign ifa.rdAddr2 = rd_a2;    assign ifb.rdAddr2 = rd_a2;
   assign ifa.wrEn = wr_en;       assign ifb.wrEn = wr_en;
   assign ifa.wrAddr = wr_addr;   assign ifb.wrAddr = wr_addr;
   assign ifa.wrLaneMask = wr_mask; assign ifb.wrLaneMask = wr_mask;
   assign ifa.wrData = wr_data;   assign ifb.wrData = wr_data;
   assign ifa.issueEn = iss_en;   assign ifb.issueEn = iss_en;
   assign ifa.issueAddr = iss_addr; assign ifb.issueAddr = iss_addr;

   simd_vector_regfile #(.ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .rf(ifa));
   simd_vector_regfile #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .rf(ifb));

   // Index 0 = zero-reg + bypass build, index 1 = plain build; second index is read port.
   logic [W-1:0] act_d [2][2];
   logic         act_b [2][2];
   assign act_d[0][0] = ifa.rdData1; assign act_d[0][1] = ifa.rdData2;
   assign act_d[1][0] = ifb.rdData1; assign act_d[1][1] = ifb.rdData2;
   assign act_b[0][0] = ifa.rdBusy1; assign act_b[0][1] = ifa.rdBusy2;
   assign act_b[1][0] = ifb.rdBusy1; assign act_b[1][1] = ifb.rdBusy2;

   logic [W-1:0] m_mem  [2][RF_DEPTH];
   logic         m_busy [2][RF_DEPTH];
   int n_checks = 0;
   int n_fail = 0;

   function automatic void model_reset();
      for (int c = 0; c < 2; c++)
         for (int a = 0; a < RF_DEPTH; a++) begin
            m_mem[c][a] = '0;
            m_busy[c][a] = 1'b0;
         end
   endfunction

   function automatic void model_edge();
      for (int c = 0; c < 2; c++) begin
         if (wr_en && !(c == 0 && wr_addr == 0)) begin
            for (int l = 0; l < RF_LANES; l++)
               if (wr_mask[l]) m_mem[c][wr_addr][l*32 +: 32] = wr_data[l*32 +: 32];
         end
         if (wr_en) m_busy[c][wr_addr] = 1'b0;
         if (iss_en && !(c == 0 && iss_addr == 0)) m_busy[c][iss_addr] = 1'b1;
      end
   endfunction

   function automatic void exp_rd(input int c, input rf_addr_t a, output logic [W-1:0] d, output logic b);
      logic zr;
      zr = (c == 0) && (a == 0);
      d = zr ? '0 : m_mem[c][a];
      b = zr ? 1'b0 : m_busy[c][a];
      if (c == 0 && rst_n && wr_en && wr_addr == a && !zr) begin
         for (int l = 0; l < RF_LANES; l++)
            if (wr_mask[l]) d[l*32 +: 32] = wr_data[l*32 +: 32];
         if (wr_mask == 4'hF) b = 1'b0;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_edge();
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      for (int a = 0; a < RF_DEPTH; a++) begin
         rd_a1 = rf_addr_t'(a);
         rd_a2 = rf_addr_t'(RF_DEPTH - 1 - a);
         #1;
         for (int c = 0; c < 2; c++)
            for (int p = 0; p < 2; p++) begin
               n_checks++;
               if (act_d[c][p] !== '0 || act_b[c][p] !== 1'b0) begin
                  n_fail++;
                  $display("FAIL reset dut%0d port%0d: got data %h busy %b, expected 0/0", c, p + 1, act_d[c][p], act_b[c][p]);
               end
            end
      end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_masked_write();
      wr_en = 1'b1; wr_addr = 4'd5; wr_mask = 4'b1111;
      wr_data = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
      tick();
      wr_mask = 4'b0101; wr_data = {4{32'h11111111}};
      tick();
      wr_en = 1'b0; rd_a1 = 4'd5; rd_a2 = 4'd5;
      #4;
      for (int c = 0; c < 2; c++)
         for (int p = 0; p < 2; p++) begin
            n_checks++;
            if (act_d[c][p] !== 128'hDEADBEEF_11111111_89ABCDEF_11111111) begin
               n_fail++;
               $display("FAIL masked_write dut%0d port%0d: got %h expected DEADBEEF1111111189ABCDEF11111111", c, p + 1, act_d[c][p]);
            end
         end
      tick();
   endtask

   task automatic test_zero_reg();
      logic [W-1:0] ed;
      logic         eb;
      wr_en = 1'b1; wr_addr = 4'd0; wr_mask = 4'hF; wr_data = '1;
      tick();
      wr_en = 1'b0; iss_en = 1'b1; iss_addr = 4'd0;
      tick();
      iss_en = 1'b0; rd_a1 = 4'd0; rd_a2 = 4'd0;
      #4;
      for (int c = 0; c < 2; c++) begin
         ed = (c == 0) ? '0 : '1;
         eb = (c == 0) ? 1'b0 : 1'b1;
         for (int p = 0; p < 2; p++) begin
            n_checks++;
            if (act_d[c][p] !== ed || act_b[c][p] !== eb) begin
               n_fail++;
               $display("FAIL zero_reg dut%0d port%0d: got %h/%b expected %h/%b", c, p + 1, act_d[c][p], act_b[c][p], ed, eb);
            end
         end
      end
      tick();
   endtask

   task automatic test_bypass();
      logic [W-1:0] ed;
      wr_en = 1'b1; wr_addr = 4'd3; wr_mask = 4'b0011; wr_data = {4{32'hA5A5A5A5}};
      rd_a1 = 4'd3; rd_a2 = 4'd3;
      #4;
      for (int c = 0; c < 2; c++) begin
         ed = (c == 0) ? 128'h00000000_00000000_A5A5A5A5_A5A5A5A5 : '0;
         for (int p = 0; p < 2; p++) begin
            n_checks++;
            if (act_d[c][p] !== ed) begin
               n_fail++;
               $display("FAIL bypass_same_cycle dut%0d port%0d: got %h expected %h", c, p + 1, act_d[c][p], ed);
            end
         end
      end
      tick();
      wr_en = 1'b0;
      #4;
      for (int c = 0; c < 2; c++)
         for (int p = 0; p < 2; p++) begin
            n_checks++;
            if (act_d[c][p] !== 128'h00000000_00000000_A5A5A5A5_A5A5A5A5) begin
               n_fail++;
               $display("FAIL bypass_next_cycle dut%0d port%0d: got %h expected 0000000000000000A5A5A5A5A5A5A5A5", c, p + 1, act_d[c][p]);
            end
         end
      tick();
   endtask

   task automatic test_scoreboard();
      logic eb;
      rd_a1 = 4'd7; rd_a2 = 4'd7;
      iss_en = 1'b1; iss_addr = 4'd7;
      tick();
      iss_en = 1'b0;
      #4;
      for (int c = 0; c < 2; c++) begin
         n_checks++;
         if (act_b[c][0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_issue dut%0d: got %b expected 1", c, act_b[c][0]);
         end
      end
      iss_en = 1'b1; wr_en = 1'b1; wr_addr = 4'd7; wr_mask = 4'hF; wr_data = {4{32'h77777777}};
      tick();
      iss_en = 1'b0; wr_en = 1'b0;
      #4;
      for (int c = 0; c < 2; c++) begin
         n_checks++;
         if (act_b[c][0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_set_wins dut%0d: got %b expected 1", c, act_b[c][0]);
         end
      end
      wr_en = 1'b1; wr_mask = 4'b0001;
      tick();
      wr_en = 1'b0;
      #4;
      for (int c = 0; c < 2; c++) begin
         n_checks++;
         if (act_b[c][0] !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_write_clears dut%0d: got %b expected 0", c, act_b[c][0]);
         end
      end
      iss_en = 1'b1;
      tick();
      iss_en = 1'b0; wr_en = 1'b1; wr_mask = 4'hF;
      #4;
      for (int c = 0; c < 2; c++) begin
         eb = (c == 0) ? 1'b0 : 1'b1;
         n_checks++;
         if (act_b[c][0] !== eb) begin
            n_fail++;
            $display("FAIL sb_full_bypass dut%0d: got %b expected %b", c, act_b[c][0], eb);
         end
      end
      tick();
      wr_en = 1'b0;
   endtask

   task automatic test_random();
      logic [W-1:0] ed;
      logic         eb;
      rf_addr_t     ra;
      for (int i = 0; i < 300; i++) begin
         wr_en    = 1'($urandom_range(0, 1));
         wr_addr  = rf_addr_t'($urandom_range(0, RF_DEPTH - 1));
         wr_mask  = rf_mask_t'($urandom_range(0, 15));
         wr_data  = {$urandom, $urandom, $urandom, $urandom};
         iss_en   = 1'($urandom_range(0, 1));
         iss_addr = ($urandom_range(0, 3) == 0) ? wr_addr : rf_addr_t'($urandom_range(0, RF_DEPTH - 1));
         rd_a1    = ($urandom_range(0, 2) == 0) ? wr_addr : rf_addr_t'($urandom_range(0, RF_DEPTH - 1));
         rd_a2    = ($urandom_range(0, 2) == 0) ? wr_addr : rf_addr_t'($urandom_range(0, RF_DEPTH - 1));
         #4;
         for (int c = 0; c < 2; c++)
            for (int p = 0; p < 2; p++) begin
               ra = (p == 0) ? rd_a1 : rd_a2;
               exp_rd(c, ra, ed, eb);
               n_checks++;
               if (act_d[c][p] !== ed || act_b[c][p] !== eb) begin
                  n_fail++;
                  $display("FAIL random[%0d] dut%0d port%0d addr %0d: got %h/%b expected %h/%b", i, c, p + 1, ra, act_d[c][p], act_b[c][p], ed, eb);
               end
            end
         tick();
      end
      wr_en = 1'b0; iss_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      wr_en = 1'b1; wr_addr = 4'd9; wr_mask = 4'hF; wr_data = 128'h5;
      tick();
      wr_en = 1'b0; iss_en = 1'b1; iss_addr = 4'd9;
      tick();
      iss_en = 1'b0; rd_a1 = 4'd9; rd_a2 = 4'd9;
      #4;
      for (int c = 0; c < 2; c++) begin
         n_checks++;
         if (act_d[c][0] !== 128'h5 || act_b[c][0] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre dut%0d: got %h/%b expected 5/1", c, act_d[c][0], act_b[c][0]);
         end
      end
      wr_en = 1'b1; wr_data = '1; iss_en = 1'b1; iss_addr = 4'd10;
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      for (int c = 0; c < 2; c++)
         for (int p = 0; p < 2; p++) begin
            n_checks++;
            if (act_d[c][p] !== '0 || act_b[c][p] !== 1'b0) begin
               n_fail++;
               $display("FAIL reset_mid_async dut%0d port%0d: got %h/%b expected 0/0", c, p + 1, act_d[c][p], act_b[c][p]);
            end
         end
      tick();
      wr_en = 1'b0; iss_en = 1'b0; rd_a2 = 4'd10;
      #2 rst_n = 1'b1;
      #2;
      for (int c = 0; c < 2; c++)
         for (int p = 0; p < 2; p++) begin
            n_checks++;
            if (act_d[c][p] !== '0 || act_b[c][p] !== 1'b0) begin
               n_fail++;
               $display("FAIL reset_mid_discard dut%0d port%0d: got %h/%b expected 0/0", c, p + 1, act_d[c][p], act_b[c][p]);
            end
         end
      tick();
   endtask

   initial begin
      rd_a1 = '0; rd_a2 = '0; wr_en = 1'b0; wr_addr = '0; wr_mask = '0; wr_data = '0;
      iss_en = 1'b0; iss_addr = '0;
      #2;
      test_reset();
      test_masked_write();
      test_zero_reg();
      test_bypass();
      test_scoreboard();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
